// File: rtl/switch_pkg.sv
// Shared widths, header field positions, arbiter state encoding and the round-robin pick helper
// used by the output daemon.
package switch_pkg;
  localparam int WORD_W  = 32;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = $clog2(NUM_SRC);

  localparam int SRC_MSB = 31;
  localparam int SRC_LSB = 24;
  localparam int LEN_MSB = 23;
  localparam int LEN_LSB = 8;
  localparam int DST_MSB = 7;
  localparam int DST_LSB = 0;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // First requester found searching upward from last+1, wrapping; last itself has lowest priority.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [SRC_W-1:0] last,
                                               input logic [NUM_SRC-1:0] req);
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] pick;
    pick = last;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + SRC_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, pointer-plus-wrap-bit full/empty; write-through on pop frees a full slot.
// dout is the head combinationally; no flow control beyond full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr;
  logic             w_rd;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd  = pop && !empty;
  // A simultaneous pop makes room, so a push into a full FIFO is still accepted.
  assign w_wr  = push && (!full || w_rd);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/output_daemon.sv
// Egress port: per-source FIFOs, round-robin whole-packet arbiter, one registered word per cycle.
// Header reaches output one cycle after it is buffered; output holds while out_ready is low, inputs never stall.
module output_daemon
  import switch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W:0]     from_input_daemon_1,
  input  logic [WORD_W:0]     from_input_daemon_2,
  input  logic [WORD_W:0]     from_input_daemon_3,
  input  logic [WORD_W:0]     from_input_daemon_4,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   output_word,
  output logic                output_valid,
  output logic [SRC_W-1:0]    grant,
  output logic [NUM_SRC-1:0]  overflow
);
  logic [WORD_W:0]    w_in   [NUM_SRC];
  logic [WORD_W-1:0]  w_head [NUM_SRC];
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   w_rem_nxt;
  logic [SRC_W-1:0]   r_grant;
  logic [SRC_W-1:0]   w_sel;
  logic [SRC_W-1:0]   w_pick;
  logic [WORD_W-1:0]  r_word;
  logic               r_valid;
  logic [NUM_SRC-1:0] r_overflow;
  logic               w_free;
  logic               w_load;

  assign w_in[0] = from_input_daemon_1;
  assign w_in[1] = from_input_daemon_2;
  assign w_in[2] = from_input_daemon_3;
  assign w_in[3] = from_input_daemon_4;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_push[g] = w_in[g][WORD_W];
    sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .din   (w_in[g][WORD_W-1:0]),
      .dout  (w_head[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  assign w_free = !r_valid || out_ready;
  assign w_pick = rr_pick(r_grant, ~w_empty);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_pop       = '0;
    w_load      = 1'b0;
    w_sel       = r_grant;
    case (r_state)
      IDLE: begin
        if (w_free && !(&w_empty)) begin
          w_sel         = w_pick;
          w_load        = 1'b1;
          w_pop[w_pick] = 1'b1;
          w_rem_nxt     = w_head[w_pick][LEN_MSB:LEN_LSB];
          w_state_nxt   = (w_rem_nxt == '0) ? IDLE : SEND;
        end
      end
      SEND: begin
        // Mid-packet the grant is locked; an empty FIFO just leaves a bubble.
        if (w_free && !w_empty[r_grant]) begin
          w_load         = 1'b1;
          w_pop[r_grant] = 1'b1;
          w_rem_nxt      = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant    <= SRC_W'(NUM_SRC - 1);
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= '0;
    end else begin
      if (w_load) begin
        r_grant <= w_sel;
        r_word  <= w_head[w_sel];
        r_valid <= 1'b1;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
      r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
    end
  end

  assign output_word  = r_word;
  assign output_valid = r_valid;
  assign grant        = r_grant;
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_output_daemon.sv
// Bench for output_daemon: vector table, directed corner sequences, and a randomized packet-level scoreboard.
module tb_output_daemon;
  import switch_pkg::*;

  localparam logic [32:0] N = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_ready = 1'b1;
  logic [32:0] tb_in [4];

  logic [31:0] ow16, ow4;
  logic        ov16, ov4;
  logic [1:0]  g16, g4;
  logic [3:0]  of16, of4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  output_daemon #(.DEPTH(16)) u_dut (
    .clk (clk), .rst (rst),
    .from_input_daemon_1 (tb_in[0]), .from_input_daemon_2 (tb_in[1]),
    .from_input_daemon_3 (tb_in[2]), .from_input_daemon_4 (tb_in[3]),
    .out_ready (out_ready), .output_word (ow16), .output_valid (ov16),
    .grant (g16), .overflow (of16)
  );

  output_daemon #(.DEPTH(4)) u_dut4 (
    .clk (clk), .rst (rst),
    .from_input_daemon_1 (tb_in[0]), .from_input_daemon_2 (tb_in[1]),
    .from_input_daemon_3 (tb_in[2]), .from_input_daemon_4 (tb_in[3]),
    .out_ready (out_ready), .output_word (ow4), .output_valid (ov4),
    .grant (g4), .overflow (of4)
  );

  typedef struct {
    bit          rst;
    logic [32:0] i0;
    logic [32:0] i1;
    logic        rdy;
    logic        ev;
    logic [31:0] ew;
    logic [1:0]  eg;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] mq [4][$];
  logic [31:0] gq [4][$];

  function automatic logic [31:0] mk_hdr(input logic [7:0] src, input logic [15:0] len,
                                         input logic [7:0] dst);
    logic [31:0] h;
    h = '0;
    h[SRC_MSB:SRC_LSB] = src;
    h[LEN_MSB:LEN_LSB] = len;
    h[DST_MSB:DST_LSB] = dst;
    return h;
  endfunction

  function automatic logic [32:0] V(input logic [31:0] w);
    return {1'b1, w};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [31:0] w, input logic [1:0] g);
    chk({nm, "_vld"}, 32'(ov16), 32'(v));
    if (v) chk({nm, "_word"}, ow16, w);
    chk({nm, "_grant"}, 32'(g16), 32'(g));
  endtask

  task automatic drive(input logic [32:0] a0, input logic [32:0] a1, input logic [32:0] a2,
                       input logic [32:0] a3, input logic r);
    tb_in[0] = a0; tb_in[1] = a1; tb_in[2] = a2; tb_in[3] = a3;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(N, N, N, N, 1'b1);
    #2;
    rst = 1'b1;
  endtask

  task automatic addv(input bit r, input logic [32:0] a0, input logic [32:0] a1, input logic rdy,
                      input logic ev, input logic [31:0] ew, input logic [1:0] eg);
    vec_t v;
    v.rst = r; v.i0 = a0; v.i1 = a1; v.rdy = rdy; v.ev = ev; v.ew = ew; v.eg = eg;
    tbl.push_back(v);
  endtask

  task automatic gen_pkt(input int s);
    int len;
    len = $urandom_range(0, 4);
    gq[s].push_back(mk_hdr(8'(s), 16'(len), 8'($urandom)));
    for (int j = 0; j < len; j++) gq[s].push_back($urandom);
  endtask

  function automatic bit model_empty();
    for (int s = 0; s < 4; s++)
      if (gq[s].size() != 0 || mq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  logic [31:0] hs, ha, hb, hp, h2, h3, ho, hr, e, pw;
  int          cur_src, cur_rem, sidx;
  logic        pv, pr, rdy, done;

  initial begin
    drive(N, N, N, N, 1'b1);

    // Single packet, contention, backpressure: rows are checked at the negedge, then drive the next edge.
    hs = mk_hdr(3, 5, 1);
    addv(1, V(hs),  N, 1, 0, 0,   3);
    addv(0, V(32),  N, 1, 0, 0,   3);
    addv(0, V(10),  N, 1, 1, hs,  0);
    addv(0, V(7),   N, 1, 1, 32,  0);
    addv(0, V(128), N, 1, 1, 10,  0);
    addv(0, V(200), N, 1, 1, 7,   0);
    addv(0, N,      N, 1, 1, 128, 0);
    addv(0, N,      N, 1, 1, 200, 0);
    addv(0, N,      N, 1, 0, 0,   0);

    ha = mk_hdr(3, 2, 1);
    hb = mk_hdr(2, 3, 2);
    addv(1, V(ha),   V(hb),   1, 0, 0,     3);
    addv(0, V('hA1), V('hB1), 1, 0, 0,     3);
    addv(0, V('hA2), V('hB2), 1, 1, ha,    0);
    addv(0, N,       V('hB3), 1, 1, 'hA1,  0);
    addv(0, N,       N,       1, 1, 'hA2,  0);
    addv(0, N,       N,       1, 1, hb,    1);
    addv(0, N,       N,       1, 1, 'hB1,  1);
    addv(0, N,       N,       1, 1, 'hB2,  1);
    addv(0, N,       N,       1, 1, 'hB3,  1);
    addv(0, N,       N,       1, 0, 0,     1);

    hp = mk_hdr(0, 3, 5);
    addv(1, V(hp),   N, 1, 0, 0,    3);
    addv(0, V('hC1), N, 1, 0, 0,    3);
    addv(0, V('hC2), N, 1, 1, hp,   0);
    addv(0, V('hC3), N, 0, 1, 'hC1, 0);
    addv(0, N,       N, 0, 1, 'hC1, 0);
    addv(0, N,       N, 0, 1, 'hC1, 0);
    addv(0, N,       N, 1, 1, 'hC1, 0);
    addv(0, N,       N, 1, 1, 'hC2, 0);
    addv(0, N,       N, 1, 1, 'hC3, 0);
    addv(0, N,       N, 1, 0, 0,    0);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        do_reset();
        chk("rst_word", ow16, 32'h0);
        chk("rst_ovf", 32'(of16), 32'h0);
      end
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ew, tbl[i].eg);
      drive(tbl[i].i0, tbl[i].i1, N, N, tbl[i].rdy);
    end

    // Stall: source 2 leaves a 2-cycle hole mid-packet while source 3 waits.
    h2 = mk_hdr(2, 4, 9);
    h3 = mk_hdr(3, 1, 7);
    @(negedge clk); do_reset(); expect_out("st0", 0, 0, 3);  drive(N, N, V(h2), V(h3), 1);
    @(negedge clk); expect_out("st1", 0, 0, 3);              drive(N, N, V('h51), V('h61), 1);
    @(negedge clk); expect_out("st2", 1, h2, 2);             drive(N, N, V('h52), N, 1);
    @(negedge clk); expect_out("st3", 1, 'h51, 2);           drive(N, N, N, N, 1);
    @(negedge clk); expect_out("st4", 1, 'h52, 2);           drive(N, N, N, N, 1);
    @(negedge clk); expect_out("st5", 0, 0, 2);              drive(N, N, V('h53), N, 1);
    @(negedge clk); expect_out("st6", 0, 0, 2);              drive(N, N, V('h54), N, 1);
    @(negedge clk); expect_out("st7", 1, 'h53, 2);           drive(N, N, N, N, 1);
    @(negedge clk); expect_out("st8", 1, 'h54, 2);
    @(negedge clk); expect_out("st9", 1, h3, 3);
    @(negedge clk); expect_out("st10", 1, 'h61, 3);
    @(negedge clk); expect_out("st11", 0, 0, 3);

    // Overflow on the DEPTH=4 instance: header parks in the output register, 4 words fill the FIFO, the 5th drops.
    ho = mk_hdr(1, 5, 3);
    @(negedge clk); do_reset(); drive(N, V(ho), N, N, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); drive(N, V(32'h100 + 32'(k)), N, N, 0);
    end
    @(negedge clk);
    chk("ovf_flag4", 32'(of4), 32'h2);
    chk("ovf_flag16", 32'(of16), 32'h0);
    chk("ovf_hold_vld", 32'(ov4), 32'h1);
    chk("ovf_hold_word", ow4, ho);
    drive(N, N, N, N, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("ovf_drain%0d_vld", k), 32'(ov4), 32'h1);
      chk($sformatf("ovf_drain%0d_word", k), ow4, 32'h100 + 32'(k));
    end
    @(negedge clk);
    chk("ovf_tail_vld", 32'(ov4), 32'h0);
    chk("ovf_tail_grant", 32'(g4), 32'h1);

    // Reset asserted mid-packet, checked before any further clock edge.
    hr = mk_hdr(0, 5, 2);
    @(negedge clk); do_reset(); drive(V(hr), N, N, N, 1);
    @(negedge clk); drive(V('h71), N, N, N, 1);
    @(negedge clk); expect_out("rmp_pre", 1, hr, 0); drive(V('h72), N, N, N, 1);
    @(negedge clk);
    expect_out("rmp_mid", 1, 'h71, 0);
    rst = 1'b0;
    drive(N, N, N, N, 1);
    #1;
    chk("rmp_async_vld", 32'(ov16), 32'h0);
    chk("rmp_async_word", ow16, 32'h0);
    chk("rmp_async_grant", 32'(g16), 32'h3);
    #1;
    rst = 1'b1;
    drive(V(mk_hdr(0, 1, 1)), V(mk_hdr(1, 1, 2)), N, N, 1);
    @(negedge clk); expect_out("rmp4", 0, 0, 3); drive(V('h11), V('h22), N, N, 1);
    @(negedge clk); expect_out("rmp5", 1, mk_hdr(0, 1, 1), 0); drive(N, N, N, N, 1);
    @(negedge clk); expect_out("rmp6", 1, 'h11, 0);
    @(negedge clk); expect_out("rmp7", 1, mk_hdr(1, 1, 2), 1);
    @(negedge clk); expect_out("rmp8", 1, 'h22, 1);
    @(negedge clk); expect_out("rmp9", 0, 0, 1);

    // Randomized traffic against a packet-level scoreboard.
    @(negedge clk); do_reset();
    pv = 1'b0; pr = 1'b1; pw = '0; cur_src = 0; cur_rem = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (pv && !pr) begin
        chk("rnd_hold_vld", 32'(ov16), 32'h1);
        chk("rnd_hold_word", ow16, pw);
      end
      if (cyc >= 1500 && model_empty() && cur_rem == 0 && !ov16) begin
        done = 1'b1;
        break;
      end
      rdy = (cyc >= 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (cur_rem > 0) chk("rnd_grant_lock", 32'(g16), 32'(cur_src));
      if (ov16 && rdy) begin
        sidx = (cur_rem > 0) ? cur_src : int'(g16);
        chk("rnd_src_has_data", 32'(mq[sidx].size() != 0), 32'h1);
        if (mq[sidx].size() != 0) begin
          e = mq[sidx].pop_front();
          if (cur_rem > 0) begin
            chk("rnd_payload", ow16, e);
            cur_rem--;
          end else begin
            chk("rnd_header", ow16, e);
            cur_src = sidx;
            cur_rem = int'(e[LEN_MSB:LEN_LSB]);
          end
        end
      end
      pv = ov16; pr = rdy; pw = ow16;
      for (int s = 0; s < 4; s++) begin
        if (cyc < 1500 && gq[s].size() == 0) gen_pkt(s);
        if (gq[s].size() != 0 && mq[s].size() < 15 && $urandom_range(0, 1) == 1) begin
          e = gq[s].pop_front();
          mq[s].push_back(e);
          tb_in[s] = V(e);
        end else begin
          tb_in[s] = N;
        end
      end
      out_ready = rdy;
    end
    chk("rnd_drained", 32'(done), 32'h1);
    chk("rnd_no_overflow", 32'(of16), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/output_daemon.md
# output_daemon

Egress stage for one switch output port. It collects the 33-bit word streams produced by the four input daemons for this port and buffers each stream in a per-source FIFO. It then forwards whole packets, never interleaved, one word per cycle on a single 32-bit output using valid/ready handshake and round-robin arbitration. There is one instance per output port, downstream of all four input daemons.

## Interface
- `DEPTH`, 16: words per source FIFO, power of two, at least 4.
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : reset, asynchronous and active-low.
- `from_input_daemon_1` … `from_input_daemon_4`  in  33 each
  - bit 32 is valid.
  - bits 31:0 are the word.
  - No backpressure toward the input daemons.
- `out_ready`  in  1  : downstream can accept a word this cycle.
- `output_word`  out  32  : current output word.
- `output_valid`  out  1  : `output_word` is valid.
- `grant`  out  2  : source index (0..3) owning the current or last packet.
- `overflow`  out  4  : sticky per-source flag, set when a word was dropped because that source's FIFO was full.

## Operation
- Packet format:
  - Header word: [31:24] source id, [23:8] payload length L (unsigned, 0..65535), [7:0] destination.
  - The header is followed by exactly L payload words.
  - All words, header included, are forwarded unmodified.
- Push rule: each cycle that `from_input_daemon_i[32]` = 1, push [31:0] into FIFO i.
- Full FIFO on push:
  - The word is dropped and `overflow[i]` is set. It clears only on reset.
  - Exception: a pop of FIFO i in the same cycle frees the slot, so the push is accepted.
- The output register is free when `!output_valid || out_ready`.
- State machine has two states, IDLE and SEND.
  - IDLE, output register free, at least one FIFO non-empty:
    - Grant the first non-empty source, searching round-robin from `grant`+1 (mod 4).
    - Pop its head, which is the header, into the output register.
    - Set `grant` and load the 16-bit `remaining` counter with L.
    - If L = 0, stay in IDLE; otherwise go to SEND.
  - SEND, output register free, FIFO[`grant`] non-empty:
    - Pop one word into the output register and decrement `remaining`.
    - When `remaining` becomes 0, go to IDLE.
  - SEND, FIFO[`grant`] empty: hold the grant and deassert `output_valid` once the current word is taken. Other sources are never served mid-packet.
  - When the output register is free and nothing is loaded, `output_valid` goes to 0.
- Packet boundaries are determined solely by the header length field. Stray words are treated as headers.

## Timing
- Reset (async assert) clears all of the following immediately, including mid-packet; any partial packet is discarded:
  - `output_valid` = 0, `output_word` = 0, `grant` = 3 (so source 0 has first priority), `overflow` = 0.
  - All FIFOs empty, state IDLE, `remaining` = 0.
- Latency:
  - A header sampled at edge k into an idle, empty-output daemon appears with `output_valid` = 1 after edge k+1.
  - Throughput is one word per cycle while `out_ready` = 1.
- Handshake:
  - A word transfers on any edge where `output_valid && out_ready`.
  - While `output_valid && !out_ready`, `output_word` and `output_valid` hold stable.
- Back-to-back packets: the header of the next packet may load in the same edge the last word of the previous packet transfers. There is no bubble.
- FIFO full/empty use a pointer-plus-wrap-bit scheme: pointers are log2(`DEPTH`)+1 bits and wrap modulo 2·`DEPTH`.

## Structure
- Package `switch_pkg` holds:
  - `WORD_W` = 32 and `NUM_SRC` = 4.
  - Header field positions: `SRC_MSB`/`LSB`, `LEN_MSB`/`LSB`, `DST_MSB`/`LSB`.
  - The state enum (IDLE, SEND).
- Sub-module `sync_fifo`:
  - Parameters `WIDTH`, `DEPTH`.
  - Ports: push, pop, din, dout (head, show-ahead), full, empty.
  - Instantiated four times.
- Arbiter and FSM live in `output_daemon`.

## Test plan
- Single packet: source 0 sends header {3, L=5, 1}, then 32, 10, 7, 128, 200, with `out_ready` = 1.
  - Required: 6 consecutive valid words in order.
  - First word appears one cycle after the header is sampled; `grant` = 0; IDLE afterward.
- Contention: sources 0 and 1 push header {3, L=2, 1} and header {2, L=3, 2} in the same cycle, each followed by its payload.
  - Required: source 0's 3 words, then source 1's 4 words, no interleave, no gap.
- Backpressure: `out_ready` held 0 for 3 cycles mid-packet.
  - Required: `output_word` stable, no word lost or duplicated, order preserved.
- Stall: source 2 header L=4, with a 2-cycle hole between payload words 2 and 3, while source 3 also has a queued packet.
  - Required: `output_valid` drops during the hole, `grant` stays 2, source 3 is served only after word 4.
- Overflow: `DEPTH` = 4, `out_ready` = 0, 6 words pushed on source 1.
  - Required: 4 retained, `overflow` = 4'b0010, the first 4 words are later drained correctly.
- Reset mid-packet: assert `rst` low during a SEND of L=5.
  - Required: outputs cleared asynchronously; a fresh packet afterward is forwarded correctly, with source 0 first.
